// File: rtl/data_memory_ctrl.sv
// Multi-cycle byte-wide data memory with a BUSYWAIT stall. Each access is
// latched on capture and then committed ACCESS_LAT-1 edges later.
module data_memory_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int ACCESS_LAT = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              busywait
);

   localparam int CNT_W = $clog2(ACCESS_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              next_state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   data_r;
   logic                op_write_r;
   logic [DATA_W-1:0]   readdata_r;
   logic                busywait_s;
   logic                req_s;
   logic                commit_s;
   logic [DATA_W-1:0]   mem_r [0:(2**ADDR_W)-1];

   assign req_s    = read | write;
   assign commit_s = (state_r == BUSY) && (cnt_r == CNT_ONE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = IDLE;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               next_state_s = BUSY;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == CNT_ONE) begin
               next_state_s = DONE;
            end else begin
               next_state_s = BUSY;
            end
         end
         // DONE never looks at the strobes, so a held request cannot retrigger.
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Output logic: the stall starts combinationally in the request cycle
   always_comb begin
      busywait_s = 1'b0;
      case (state_r)
         IDLE:    busywait_s = req_s;
         BUSY:    busywait_s = 1'b1;
         DONE:    busywait_s = 1'b0;
         default: busywait_s = 1'b0;
      endcase
   end

   // Request capture and latency counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r      <= CNT_ZERO;
         addr_r     <= {ADDR_W{1'b0}};
         data_r     <= {DATA_W{1'b0}};
         op_write_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  cnt_r      <= CNT_LOAD;
                  addr_r     <= address;
                  data_r     <= writedata;
                  op_write_r <= write;
               end
            end
            BUSY:    cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Memory array: not cleared by reset, and a reset edge drops a pending write
   always_ff @(posedge clk) begin
      if (!reset && commit_s && op_write_r) begin
         mem_r[addr_r] <= data_r;
      end
   end

   // Load data register, updated only by a completed read
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_r <= {DATA_W{1'b0}};
      end else if (commit_s && !op_write_r) begin
         readdata_r <= mem_r[addr_r];
      end
   end

   assign readdata = readdata_r;
   assign busywait = busywait_s;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: stimulus pushes expected responses,
// a negedge monitor checks each completed access as BUSYWAIT drops.
module tb_data_memory_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       read;
   logic       write;
   logic [7:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       busywait;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [7:0] prev;   // READDATA value required throughout the stall
      logic [7:0] data;   // READDATA value required in the DONE cycle
      int         len;    // required number of BUSYWAIT-high cycles
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model_rd;

   data_memory_ctrl #(.ADDR_W(8), .DATA_W(8), .ACCESS_LAT(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .read      (read),
      .write     (write),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .busywait  (busywait)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic rd, input logic wr, input logic [7:0] exp_rd);
      exp_t e;
      e.prev = model_rd;
      e.data = (rd && !wr) ? exp_rd : model_rd;
      e.len  = 5;
      sb.push_back(e);
      model_rd = e.data;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (busywait && n < 20);
      if (busywait) begin
         checks++;
         $display("FAIL %s: busywait still %0b after %0d cycles, expected 0", name, busywait, n);
      end
   endtask

   task automatic do_access(input string name, input logic rd, input logic wr,
                            input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      @(posedge clk); #1;
      read = rd; write = wr; address = a; writedata = d;
      push_exp(rd, wr, exp_rd);
      @(posedge clk); #1;
      // Captured; scramble the bus to show the latched copy is what commits.
      read = 1'b0; write = 1'b0; address = ~a; writedata = ~d;
      wait_done(name);
      @(posedge clk); #1;
   endtask

   // Monitor: measure each stall, then pop and compare when BUSYWAIT falls
   initial begin
      int   run = 0;
      logic stable = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            run = 0;
            stable = 1'b1;
         end else if (busywait) begin
            if (sb.size() > 0 && readdata !== sb[0].prev) stable = 1'b0;
            run++;
         end else if (run > 0) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_access: got stall of %0d cycles, expected none", run);
            end else begin
               e = sb.pop_front();
               check("readdata_done", {24'd0, readdata}, {24'd0, e.data});
               check("busy_len", run, e.len);
               check("readdata_stable", {31'd0, stable}, 32'd1);
            end
            run = 0;
            stable = 1'b1;
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
      model_rd = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busywait", {31'd0, busywait}, 32'd0);
      check("reset_readdata", {24'd0, readdata}, 32'd0);
      reset = 1'b0;

      // Write then read back
      do_access("wr_10", 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
      do_access("rd_10", 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);

      // Simultaneous strobes act as a write
      do_access("rw_20", 1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
      do_access("rd_20", 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);

      // Reset aborts a pending write
      do_access("wr_30", 1'b0, 1'b1, 8'h30, 8'h11, 8'h00);
      do_access("rd_30", 1'b1, 1'b0, 8'h30, 8'h00, 8'h11);
      @(posedge clk); #1;
      write = 1'b1; address = 8'h30; writedata = 8'hFF;
      @(posedge clk); #1;
      write = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busywait", {31'd0, busywait}, 32'd0);
      check("abort_readdata", {24'd0, readdata}, 32'd0);
      reset = 1'b0;
      model_rd = 8'h00;
      do_access("rd_30_after_abort", 1'b1, 1'b0, 8'h30, 8'h00, 8'h11);

      // Held strobe: one commit per capture, recapture one edge after DONE
      @(posedge clk); #1;
      write = 1'b1; address = 8'h40; writedata = 8'h55;
      push_exp(1'b0, 1'b1, 8'h00);
      @(posedge clk); #1;
      writedata = 8'h66;
      push_exp(1'b0, 1'b1, 8'h00);
      wait_done("held_first");
      @(posedge clk); #1;
      check("held_recapture_busywait", {31'd0, busywait}, 32'd1);
      @(posedge clk); #1;
      write = 1'b0;
      wait_done("held_second");
      @(posedge clk); #1;
      do_access("rd_40", 1'b1, 1'b0, 8'h40, 8'h00, 8'h66);

      // Top and bottom addresses do not alias
      do_access("wr_ff", 1'b0, 1'b1, 8'hFF, 8'h7E, 8'h00);
      do_access("wr_00", 1'b0, 1'b1, 8'h00, 8'h81, 8'h00);
      do_access("rd_ff", 1'b1, 1'b0, 8'hFF, 8'h00, 8'h7E);
      do_access("rd_00", 1'b1, 1'b0, 8'h00, 8'h00, 8'h81);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
